// File: rtl/apple_placer.sv
// -----------------------------------------------------------------------------
// apple_placer
//
// Holds the snake game's apple position. On a gameplay frame tick where the
// snake head overlaps the apple, it scores the eat, samples new coordinates from
// the free-running random generator, and rejects candidates that land on the
// head. After MAX_RETRY rejections the next candidate is taken as-is so that
// placement always finishes in bounded time.
//
// Optional feature macro: APPLE_TIMEOUT_EN
//   When defined, an apple left uneaten for TIMEOUT_FRAMES gameplay frames is
//   relocated without scoring.
//
// Ports:
//   VGA_clk      in   system clock, the only clock
//   reset        in   asynchronous active-high reset
//   frame_tick   in   one-cycle pulse per gameplay update
//   game_active  in   eat detection enabled only while high
//   rand_Pos     in   random X candidate (20..620)
//   rand_Y       in   random Y candidate (20..460)
//   head_x/y     in   snake head top-left corner
//   apple_x/y    out  current apple top-left corner
//   apple_valid  out  apple position stable and drawable
//   eaten        out  one-cycle pulse per eat
//   score        out  apples eaten, saturating
// -----------------------------------------------------------------------------
module apple_placer #(
  parameter int APPLE_SIZE     = 10,
  parameter int MAX_RETRY      = 4,
  parameter int SCORE_W        = 8,
  parameter int RESET_X        = 320,
  parameter int RESET_Y        = 240,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic               VGA_clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               game_active,
  input  logic [9:0]         rand_Pos,
  input  logic [8:0]         rand_Y,
  input  logic [9:0]         head_x,
  input  logic [8:0]         head_y,
  output logic [9:0]         apple_x,
  output logic [8:0]         apple_y,
  output logic               apple_valid,
  output logic               eaten,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SAMPLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  // Elaboration-time sanity check on the relocation period.
  if (TIMEOUT_FRAMES < 1) begin : g_bad_timeout
    $error("apple_placer: TIMEOUT_FRAMES must be at least 1");
  end

  // Square-vs-square overlap of the head and a box at (ax, ay). Sums are
  // widened by one bit so a box near the right/bottom edge cannot wrap.
  function automatic logic overlap(input logic [9:0] hx, input logic [8:0] hy,
                                   input logic [9:0] ax, input logic [8:0] ay);
    logic [10:0] hx_e, ax_e;
    logic [9:0]  hy_e, ay_e;
    hx_e = {1'b0, hx};
    ax_e = {1'b0, ax};
    hy_e = {1'b0, hy};
    ay_e = {1'b0, ay};
    return (hx_e + 11'(APPLE_SIZE) > ax_e) && (hx_e < ax_e + 11'(APPLE_SIZE)) &&
           (hy_e + 10'(APPLE_SIZE) > ay_e) && (hy_e < ay_e + 10'(APPLE_SIZE));
  endfunction

  state_t             state_q, state_d;
  logic [RETRY_W-1:0] retry_q;
  logic [9:0]         cand_x;
  logic [8:0]         cand_y;

  logic eat_hit;
  logic cand_hit;
  logic retry_full;
  logic start_eat;
  logic start_relocate;
  logic accept;
  logic reject;

  assign eat_hit    = frame_tick && game_active && overlap(head_x, head_y, apple_x, apple_y);
  assign cand_hit   = overlap(head_x, head_y, cand_x, cand_y);
  assign retry_full = (retry_q >= RETRY_W'(MAX_RETRY));

`ifdef APPLE_TIMEOUT_EN
  localparam int FRAME_W = (TIMEOUT_FRAMES < 2) ? 1 : $clog2(TIMEOUT_FRAMES);

  logic [FRAME_W-1:0] frame_cnt;
  logic               timeout_hit;

  assign timeout_hit = frame_tick && game_active &&
                       (frame_cnt == FRAME_W'(TIMEOUT_FRAMES - 1));

  // Counts idle gameplay frames in HOLD; restarts whenever a placement begins
  // or ends, so each newly placed apple gets the full period.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (accept || start_eat || start_relocate) begin
      frame_cnt <= '0;
    end else if (state_q == HOLD && frame_tick && game_active) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
    end else begin
      // NOTE: every clocked register uses <= so all flops update from the
      // same pre-edge values; a blocking = here would create ordering races.
      state_q <= state_d;
    end
  end

  // Next-state and placement control strobes.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; a missing
    // assignment in some branch would infer a latch.
    state_d        = state_q;
    start_eat      = 1'b0;
    start_relocate = 1'b0;
    accept         = 1'b0;
    reject         = 1'b0;
    unique case (state_q)
      HOLD: begin
        // An eat takes priority over a simultaneous timeout.
        if (eat_hit) begin
          start_eat = 1'b1;
          state_d   = SAMPLE;
        end else if (timeout_hit) begin
          start_relocate = 1'b1;
          state_d        = SAMPLE;
        end
      end
      SAMPLE: state_d = CHECK;
      CHECK: begin
        if (cand_hit && !retry_full) begin
          reject  = 1'b1;
          state_d = SAMPLE;
        end else begin
          accept  = 1'b1;
          state_d = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // Apple position, score and handshake outputs.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      apple_x     <= 10'(RESET_X);
      apple_y     <= 9'(RESET_Y);
      apple_valid <= 1'b1;
      eaten       <= 1'b0;
      score       <= '0;
      retry_q     <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
    end else begin
      eaten <= start_eat;

      if (start_eat || start_relocate) begin
        apple_valid <= 1'b0;
        retry_q     <= '0;
      end

      if (start_eat && score != {SCORE_W{1'b1}}) begin
        score <= score + SCORE_W'(1);
      end

      if (state_q == SAMPLE) begin
        cand_x <= rand_Pos;
        cand_y <= rand_Y;
      end

      if (reject) begin
        retry_q <= retry_q + RETRY_W'(1);
      end

      // The published position moves only here, so it is constant whenever
      // apple_valid is high.
      if (accept) begin
        apple_x     <= cand_x;
        apple_y     <= cand_y;
        apple_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apple_placer.sv
// -----------------------------------------------------------------------------
// tb_apple_placer
//
// Directed and randomized stimulus for apple_placer. Expected values come from
// a placement-level model: for each placement the random candidates offered in
// the sampling cycles are generated up front, the first one clear of the head
// (or the one after MAX_RETRY rejections) is the expected apple, and its
// acceptance cycle follows from the sample/check cadence.
// Build with +define+APPLE_TIMEOUT_EN to exercise forced relocation.
// -----------------------------------------------------------------------------
module tb_apple_placer;

  localparam int MR = 4;
`ifdef APPLE_TIMEOUT_EN
  localparam int TO = 3;
`else
  localparam int TO = 600;
`endif

  logic       VGA_clk;
  logic       reset;
  logic       frame_tick;
  logic       game_active;
  logic [9:0] rand_Pos;
  logic [8:0] rand_Y;
  logic [9:0] head_x;
  logic [8:0] head_y;
  logic [9:0] apple_x;
  logic [8:0] apple_y;
  logic       apple_valid;
  logic       eaten;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;

  // Model state.
  int exp_ax    = 320;
  int exp_ay    = 240;
  int exp_score = 0;

  apple_placer #(
    .APPLE_SIZE(10), .MAX_RETRY(MR), .SCORE_W(8),
    .RESET_X(320), .RESET_Y(240), .TIMEOUT_FRAMES(TO)
  ) dut (
    .VGA_clk(VGA_clk), .reset(reset), .frame_tick(frame_tick),
    .game_active(game_active), .rand_Pos(rand_Pos), .rand_Y(rand_Y),
    .head_x(head_x), .head_y(head_y), .apple_x(apple_x), .apple_y(apple_y),
    .apple_valid(apple_valid), .eaten(eaten), .score(score)
  );

  initial VGA_clk = 1'b0;
  always #5 VGA_clk = ~VGA_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_ov(int hx, int hy, int ax, int ay);
    return (hx + 10 > ax) && (hx < ax + 10) && (hy + 10 > ay) && (hy < ay + 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge VGA_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " eaten"}, eaten, 0);
    check({tag, " valid"}, apple_valid, 1);
    check({tag, " apple_x"}, apple_x, exp_ax);
    check({tag, " apple_y"}, apple_y, exp_ay);
    check({tag, " score"}, score, exp_score);
  endtask

  // One full placement: a triggering frame tick with the head at (tx,ty),
  // then the head parked at (px,py) while candidates are offered. With fixed
  // set every cycle offers (fx,fy); otherwise candidates are random. With
  // noise set, frame_tick and game_active toggle randomly during placement.
  task automatic place(input string tag, input int tx, input int ty, input bit is_eat,
                       input int px, input int py, input bit fixed,
                       input int fx, input int fy, input bit noise);
    int rx[1:2*MR+1];
    int ry[1:2*MR+1];
    int j, acc, old_x, old_y, cx, cy;
    for (int o = 1; o <= 2*MR+1; o++) begin
      rx[o] = fixed ? fx : int'($urandom_range(20, 620));
      ry[o] = fixed ? fy : int'($urandom_range(20, 460));
    end
    // Candidate j is offered in cycle 1+2j after the trigger.
    j = 0;
    while (j < MR && ref_ov(px, py, rx[1+2*j], ry[1+2*j])) j++;
    cx    = rx[1+2*j];
    cy    = ry[1+2*j];
    acc   = 3 + 2*j;
    old_x = exp_ax;
    old_y = exp_ay;
    if (is_eat && exp_score < 255) exp_score++;

    head_x      = 10'(tx);
    head_y      = 9'(ty);
    frame_tick  = 1'b1;
    game_active = 1'b1;
    step();
    for (int o = 1; o <= acc; o++) begin
      check({tag, " eaten"}, eaten, (is_eat && o == 1));
      check({tag, " valid"}, apple_valid, (o == acc));
      check({tag, " apple_x"}, apple_x, (o == acc) ? cx : old_x);
      check({tag, " apple_y"}, apple_y, (o == acc) ? cy : old_y);
      check({tag, " score"}, score, exp_score);
      if (o < acc) begin
        head_x      = 10'(px);
        head_y      = 9'(py);
        rand_Pos    = 10'(rx[o]);
        rand_Y      = 9'(ry[o]);
        frame_tick  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        game_active = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
      end
    end
    frame_tick  = 1'b0;
    game_active = 1'b1;
    exp_ax      = cx;
    exp_ay      = cy;
  endtask

  initial begin
    int hx, hy, fx, fy;
    bit fixed;

    reset       = 1'b1;
    frame_tick  = 1'b0;
    game_active = 1'b0;
    rand_Pos    = '0;
    rand_Y      = '0;
    head_x      = 10'd100;
    head_y      = 9'd100;
    repeat (2) @(posedge VGA_clk);
    #1;
    check_idle("in_reset");
    reset = 1'b0;

    // Ticks with the head away from the apple: nothing happens.
    game_active = 1'b1;
`ifdef APPLE_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
`else
    for (int i = 0; i < 6; i++) begin
`endif
      frame_tick = 1'b1;
      step();
      check_idle("idle_ticks");
    end
    frame_tick = 1'b0;

    // Basic eat with an immediately accepted candidate.
    place("eat_basic", 325, 245, 1, 100, 100, 1, 500, 300, 0);
    // Candidate pinned onto the head: MAX_RETRY rejections, then forced accept.
    place("eat_retry", exp_ax, exp_ay, 1, 325, 245, 1, 330, 250, 0);

    // Head on apple but game inactive: no eat.
    head_x      = 10'(exp_ax);
    head_y      = 9'(exp_ay);
    game_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1;
      step();
      check_idle("inactive");
    end
    game_active = 1'b1;
    frame_tick  = 1'b0;

    // Stray ticks and game_active toggling during placement are ignored.
    place("noisy", exp_ax, exp_ay, 1, 200, 200, 1, 205, 195, 1);

    // Randomized placements, some with candidates forced near the head.
    for (int n = 0; n < 24; n++) begin
      hx    = int'($urandom_range(20, 600));
      hy    = int'($urandom_range(20, 440));
      fixed = 1'($urandom_range(0, 1));
      fx    = hx + int'($urandom_range(0, 18)) - 9;
      fy    = hy + int'($urandom_range(0, 18)) - 9;
      place("random", exp_ax, exp_ay, 1, hx, hy, fixed, fx, fy, 1'($urandom_range(0, 1)));
    end

`ifndef APPLE_TIMEOUT_EN
    // Without the timeout feature the apple never moves on its own.
    head_x = 10'd0;
    head_y = 9'd0;
    for (int i = 0; i < 20; i++) begin
      frame_tick = 1'b1;
      step();
      check_idle("no_timeout");
    end
    frame_tick = 1'b0;
`endif

    // Drive the score to saturation, then eat once more.
    while (exp_score < 255) place("fill", exp_ax, exp_ay, 1, 0, 0, 0, 0, 0, 0);
    place("saturated", exp_ax, exp_ay, 1, 0, 0, 0, 0, 0, 0);

    // Reset asserted while in CHECK returns everything immediately.
    head_x     = 10'(exp_ax);
    head_y     = 9'(exp_ay);
    frame_tick = 1'b1;
    step();
    check("mid eaten", eaten, 1);
    frame_tick = 1'b0;
    head_x     = 10'd0;
    head_y     = 9'd0;
    rand_Pos   = 10'd400;
    rand_Y     = 9'd400;
    step();
    check("mid valid_low", apple_valid, 0);
    #2;
    reset = 1'b1;
    #1;
    exp_ax    = 320;
    exp_ay    = 240;
    exp_score = 0;
    check_idle("async_reset");
    step();
    reset = 1'b0;
    step();
    check_idle("after_reset");

`ifdef APPLE_TIMEOUT_EN
    // Head away: the TO-th tick relocates without scoring.
    head_x = 10'd0;
    head_y = 9'd0;
    for (int i = 0; i < TO - 1; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      check_idle("to_wait");
    end
    place("timeout", 0, 0, 0, 0, 0, 1, 450, 150, 0);
    // Head on the apple at the TO-th tick: treated as an eat.
    for (int i = 0; i < TO - 1; i++) begin
      frame_tick = 1'b1;
      step();
      check_idle("to_wait2");
    end
    place("timeout_eat", exp_ax, exp_ay, 1, 0, 0, 1, 100, 400, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
